// File: rtl/periph_pkg.sv
// Purpose: shared register map, TCON bit layout and constants for the timer peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package periph_pkg;

    // Per-channel register offsets within a 0x20-byte channel window
    localparam logic [4:0] OFF_TH    = 5'h00;
    localparam logic [4:0] OFF_TL    = 5'h04;
    localparam logic [4:0] OFF_TCON  = 5'h08;
    localparam logic [4:0] OFF_PRESC = 5'h0C;

    // Global register offsets relative to the window base
    localparam logic [8:0] OFF_IRQSTAT = 9'h100;
    localparam logic [8:0] OFF_LED     = 9'h104;
    localparam logic [8:0] OFF_SWITCH  = 9'h108;
    localparam logic [8:0] OFF_DIGI    = 9'h10C;

    // TCON bit indices
    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_PEND = 2;
    localparam int TCON_MODE = 3;

    // Value returned for reads that hit no register
    localparam logic [31:0] UNMAPPED_RDATA = 32'hcdcdcdcd;

    // Packed view of TCON; field order matches the bit indices above
    typedef struct packed {
        logic mode;   // 0 auto-reload, 1 one-shot
        logic pend;
        logic ie;
        logic en;
    } tcon_t;

endpackage

// File: rtl/timer_channel.sv
// Purpose: one timer channel: prescaler, up-counter with reload, control/pending register.
// Latency: register writes visible the cycle after the write edge; tick is combinational.
// Backpressure: none; writes always accepted, bus write beats same-cycle tick update.
module timer_channel
    import periph_pkg::*;
#(
    parameter int DW = 32,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          th_wr,
    input  logic          tl_wr,
    input  logic          tcon_wr,
    input  logic          presc_wr,
    input  logic [DW-1:0] wdata_dw,
    input  logic [PW-1:0] wdata_pw,
    input  logic [3:0]    wdata_tcon,
    output logic [DW-1:0] th,
    output logic [DW-1:0] tl,
    output tcon_t         tcon,
    output logic [PW-1:0] presc
);

    logic [PW-1:0] pcnt;
    logic          tick;
    logic          ovf;

    assign tick = tcon.en && (pcnt == presc);
    assign ovf  = tick && (tl == '1);

    // Prescaler: idles at 0 when disabled, wraps on tick, restarts on PRESC write
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (presc_wr || !tcon.en || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + PW'(1);
    end

    // Reload and prescale registers are software-owned only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th    <= '0;
            presc <= '0;
        end else begin
            if (th_wr)    th    <= wdata_dw;
            if (presc_wr) presc <= wdata_pw;
        end
    end

    // Counter: bus write wins, otherwise count on tick and reload on overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tl <= '0;
        else if (tl_wr)
            tl <= wdata_dw;
        else if (tick)
            tl <= (tl == '1) ? th : tl + DW'(1);
    end

    // Control: bus write wins for en/ie/mode; a pending set survives a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon <= '0;
        end else begin
            if (tcon_wr) begin
                tcon.en   <= wdata_tcon[TCON_EN];
                tcon.ie   <= wdata_tcon[TCON_IE];
                tcon.mode <= wdata_tcon[TCON_MODE];
            end else if (ovf && tcon.mode) begin
                tcon.en <= 1'b0;
            end
            tcon.pend <= (ovf && tcon.ie) ||
                         (tcon.pend && !(tcon_wr && wdata_tcon[TCON_PEND]));
        end
    end

endmodule

// File: rtl/multi_timer_periph.sv
// Purpose: bus-mapped bank of timer channels plus LED, switch and seven-segment registers.
// Latency: zero-cycle combinational read data; writes take effect on the strobed clk edge.
// Backpressure: none; every access completes in its cycle, accessible flags report hits.
module multi_timer_periph
    import periph_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          DW         = 32,
    parameter int          PW         = 16,
    parameter logic [30:0] BASE_ADDR  = 31'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        r_accessible,
    output logic        w_accessible,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi,
    output logic        irqout
);

    logic [30:0] off;
    logic [2:0]  ch_sel;
    logic [4:0]  ch_reg;
    logic        ch_hit;
    logic        glb_win;
    logic        irqstat_hit, led_hit, switch_hit, digi_hit;
    logic        unused_bits;

    logic [DW-1:0]         th_q    [NUM_TIMERS];
    logic [DW-1:0]         tl_q    [NUM_TIMERS];
    tcon_t                 tcon_q  [NUM_TIMERS];
    logic [PW-1:0]         presc_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pend_vec;

    // Bit 31 is outside the decoded window
    assign unused_bits = ^{addr[31], wdata};

    assign off    = addr[30:0] - BASE_ADDR;
    assign ch_sel = off[7:5];
    assign ch_reg = off[4:0];
    assign ch_hit = (off[30:8] == '0) && ({1'b0, ch_sel} < 4'(NUM_TIMERS)) &&
                    (ch_reg inside {OFF_TH, OFF_TL, OFF_TCON, OFF_PRESC});

    assign glb_win     = (off[30:9] == '0);
    assign irqstat_hit = glb_win && (off[8:0] == OFF_IRQSTAT);
    assign led_hit     = glb_win && (off[8:0] == OFF_LED);
    assign switch_hit  = glb_win && (off[8:0] == OFF_SWITCH);
    assign digi_hit    = glb_win && (off[8:0] == OFF_DIGI);

    assign w_accessible = wr && (ch_hit || led_hit || digi_hit);
    assign irqout       = |pend_vec;

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
        logic sel;
        assign sel = wr && ch_hit && (ch_sel == 3'(gi));

        timer_channel #(.DW(DW), .PW(PW)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .th_wr      (sel && (ch_reg == OFF_TH)),
            .tl_wr      (sel && (ch_reg == OFF_TL)),
            .tcon_wr    (sel && (ch_reg == OFF_TCON)),
            .presc_wr   (sel && (ch_reg == OFF_PRESC)),
            .wdata_dw   (wdata[DW-1:0]),
            .wdata_pw   (wdata[PW-1:0]),
            .wdata_tcon (wdata[3:0]),
            .th         (th_q[gi]),
            .tl         (tl_q[gi]),
            .tcon       (tcon_q[gi]),
            .presc      (presc_q[gi])
        );

        assign pend_vec[gi] = tcon_q[gi].pend;
    end

    // LED and seven-segment output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led  <= '0;
            digi <= '0;
        end else begin
            if (wr && led_hit)  led  <= wdata[7:0];
            if (wr && digi_hit) digi <= wdata[11:0];
        end
    end

    // Read mux: zero-extend the hit register, marker value when nothing is hit
    always_comb begin
        rdata        = UNMAPPED_RDATA;
        r_accessible = 1'b0;
        if (ch_hit) begin
            rdata        = '0;
            r_accessible = rd;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (ch_sel == 3'(i)) begin
                    case (ch_reg)
                        OFF_TH:    rdata[DW-1:0] = th_q[i];
                        OFF_TL:    rdata[DW-1:0] = tl_q[i];
                        OFF_TCON:  rdata[3:0]    = tcon_q[i];
                        OFF_PRESC: rdata[PW-1:0] = presc_q[i];
                        default:   ;
                    endcase
                end
            end
        end else if (irqstat_hit) begin
            rdata                   = '0;
            rdata[NUM_TIMERS-1:0]   = pend_vec;
            r_accessible            = rd;
        end else if (led_hit) begin
            rdata                   = {24'd0, led};
            r_accessible            = rd;
        end else if (switch_hit) begin
            rdata                   = {24'd0, switch};
            r_accessible            = rd;
        end else if (digi_hit) begin
            rdata                   = {20'd0, digi};
            r_accessible            = rd;
        end
    end

endmodule

// File: doc/multi_timer_periph.md
MULTI_TIMER_PERIPH -- requirements
Module: multi_timer_periph

Interface
REQ-001 SHALL have parameter NUM_TIMERS, 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter DW, 32, timer counter/reload width (8..32), zero-extended on read.
REQ-003 SHALL have parameter PW, 16, prescaler width.
REQ-004 SHALL have parameter BASE_ADDR, 31'h40000000, base of the register window; decode uses addr[30:0] only.
REQ-005 SHALL have port clk, input, 1, system clock; one clock domain.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports rd and wr, input, 1 each, read and write strobes.
REQ-008 SHALL have ports addr and wdata, input, 32 each, bus address and write data.
REQ-009 SHALL have port rdata, output, 32, read data.
REQ-010 SHALL have ports r_accessible and w_accessible, output, 1 each, address-hit flags.
REQ-011 SHALL have port led, output, 8, LED register.
REQ-012 SHALL have port switch, input, 8, switch inputs.
REQ-013 SHALL have port digi, output, 12, seven-segment register.
REQ-014 SHALL have port irqout, output, 1, OR of all channel pending bits.

Function
REQ-015 SHALL map channel i at BASE_ADDR+0x20*i: +0x0 TH (reload), +0x4 TL (count), +0x8 TCON, +0xC PRESC.
REQ-016 SHALL define TCON bits: [0] enable, [1] irq enable, [2] pending (read; write-1-to-clear), [3] mode (0 auto-reload, 1 one-shot).
REQ-017 SHALL map BASE_ADDR+0x100 IRQSTAT (read-only, bit i = pending of channel i), +0x104 led, +0x108 switch (read-only), +0x10C digi.
REQ-018 SHALL return rdata combinationally (zero latency); unmapped reads return 32'hcdcdcdcd with r_accessible=0.
REQ-019 SHALL drive w_accessible combinationally: 1 when wr is high and addr hits a writable register, else 0.
REQ-020 SHALL apply writes on the rising clk edge with wr high; writes to read-only or unmapped addresses have no effect.
REQ-021 SHALL hold a per-channel prescaler counter that, while enable=1, counts 0..PRESC and emits a one-cycle tick when it equals PRESC, then returns to 0; PRESC=0 ticks every cycle.
REQ-022 SHALL hold the prescaler counter at 0 while enable=0, and clear it on any PRESC write.
REQ-023 SHALL increment TL on tick; on tick with TL all-ones, load TL<=TH and set pending if irq enable=1.
REQ-024 SHALL, in one-shot mode, also clear enable on that overflow tick.
REQ-025 SHALL give a bus write to TL or TCON priority over the same-cycle tick update of that register.
REQ-026 SHALL give pending-set priority over a same-cycle write-1-to-clear.
REQ-027 SHALL drive irqout as the combinational OR of all pending bits.

Reset
REQ-028 SHALL asynchronously clear TH, TL, TCON, PRESC, prescaler counters, led and digi to 0 while reset=1; irqout=0 during reset.
REQ-029 SHALL abort any count in progress on reset; counting resumes only after software sets enable.

Structure
REQ-030 SHALL place register offsets, TCON bit indices and the unmapped-read constant in shared package periph_pkg.
REQ-031 SHALL implement one channel as sub-module timer_channel, instantiated NUM_TIMERS times by generate.

Verification
REQ-032 SHALL cover: TH=0xFFFFFFFC, TL=0xFFFFFFFE, PRESC=0, TCON=0b0011 -> pending and irqout rise 2 cycles after enable, TL=0xFFFFFFFC.
REQ-033 SHALL cover: PRESC=3, TL=0, enable -> TL increments once every 4 cycles.
REQ-034 SHALL cover: one-shot mode overflow -> TCON reads 0b1110, TL holds TH thereafter.
REQ-035 SHALL cover: write TCON bit2=1 in the overflow cycle -> pending remains 1; next write clears it, irqout=0.
REQ-036 SHALL cover: read 0x40000200 -> rdata=0xcdcdcdcd, r_accessible=0; write 0x40000108 -> w_accessible=0, no state change.
REQ-037 SHALL cover: reset asserted mid-count on channel 1 -> all registers 0 immediately, irqout=0.
